// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target byte engine with fixed 7-bit address (optional SCL stretch: I2C_TARGET_CLK_STRETCH_EN)
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h3C
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       is_sending_o,
    output logic       scl_hold_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       tx_req_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       busy_o,
    output logic       stop_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_WAIT_STOP
    } state_t;

    state_t     r_state, w_state;
    logic [7:0] r_shift, w_shift;
    logic [2:0] r_cnt, w_cnt;
    logic       r_rw, w_rw;
    logic       r_phase, w_phase;
    logic       r_load, w_load;
    logic       r_sending, w_sending;
    logic       r_busy, w_busy;
    logic [7:0] r_rx_data, w_rx_data;
    logic       r_rx_valid, w_rx_valid;
    logic       r_tx_req, w_tx_req;
    logic       r_stop, w_stop;
    logic       r_hold, w_hold;
    logic       r_scl_s1, r_scl_s2, r_scl_prev;
    logic       r_sda_s1, r_sda_s2, r_sda_prev;
    logic       w_scl_rise, w_scl_fall, w_start, w_stop_cond;
    logic       w_unused;

    // Synchronise the pins and keep one previous sample; reset to idle-bus level so release creates no false STOP
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_prev <= 1'b1;
            r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_prev <= 1'b1;
        end else begin
            r_scl_s1 <= scl_i; r_scl_s2 <= r_scl_s1; r_scl_prev <= r_scl_s2;
            r_sda_s1 <= sda_i; r_sda_s2 <= r_sda_s1; r_sda_prev <= r_sda_s2;
        end
    end

    assign w_scl_rise  = r_scl_s2 & ~r_scl_prev;
    assign w_scl_fall  = ~r_scl_s2 & r_scl_prev;
    assign w_start     = r_scl_s2 & r_sda_prev & ~r_sda_s2;
    assign w_stop_cond = r_scl_s2 & ~r_sda_prev & r_sda_s2;

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_shift    <= 8'h00;
            r_cnt      <= 3'd0;
            r_rw       <= 1'b0;
            r_phase    <= 1'b0;
            r_load     <= 1'b0;
            r_sending  <= 1'b0;
            r_busy     <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_stop     <= 1'b0;
            r_hold     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_shift    <= w_shift;
            r_cnt      <= w_cnt;
            r_rw       <= w_rw;
            r_phase    <= w_phase;
            r_load     <= w_load;
            r_sending  <= w_sending;
            r_busy     <= w_busy;
            r_rx_data  <= w_rx_data;
            r_rx_valid <= w_rx_valid;
            r_tx_req   <= w_tx_req;
            r_stop     <= w_stop;
            r_hold     <= w_hold;
        end
    end

    // Next-state logic; bus START/STOP override all per-state handling
    always_comb begin
        w_state    = r_state;
        w_shift    = r_shift;
        w_cnt      = r_cnt;
        w_rw       = r_rw;
        w_phase    = r_phase;
        w_load     = r_load;
        w_sending  = r_sending;
        w_busy     = r_busy;
        w_rx_data  = r_rx_data;
        w_rx_valid = 1'b0;
        w_tx_req   = 1'b0;
        w_stop     = 1'b0;
        w_hold     = r_hold;
        if (w_stop_cond) begin
            w_state = S_IDLE; w_sending = 1'b0; w_busy = 1'b0; w_hold = 1'b0;
            w_load = 1'b0; w_phase = 1'b0; w_cnt = 3'd0; w_stop = 1'b1;
        end else if (w_start) begin
            w_state = S_ADDR; w_sending = 1'b0; w_busy = 1'b0; w_hold = 1'b0;
            w_load = 1'b0; w_phase = 1'b0; w_cnt = 3'd0;
        end else begin
            case (r_state)
                S_ADDR: if (w_scl_rise) begin
                    w_shift = {r_shift[6:0], r_sda_s2};
                    w_cnt   = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_rw    = r_sda_s2;
                        w_phase = 1'b0;
                        w_state = (r_shift[6:0] == TARGET_ADDR) ? S_ADDR_ACK : S_WAIT_STOP;
                    end
                end
                S_ADDR_ACK: if (w_scl_fall) begin
                    if (!r_phase) begin
                        w_sending = 1'b1; w_busy = 1'b1; w_phase = 1'b1;
                    end else begin
                        w_sending = 1'b0; w_phase = 1'b0; w_cnt = 3'd0;
                        if (r_rw) begin
                            w_state = S_READ; w_tx_req = 1'b1; w_load = 1'b1;
                        end else begin
                            w_state = S_WRITE;
                        end
                    end
                end
                S_WRITE: if (w_scl_rise) begin
                    w_shift = {r_shift[6:0], r_sda_s2};
                    w_cnt   = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_rx_data = {r_shift[6:0], r_sda_s2}; w_rx_valid = 1'b1;
                        w_state   = S_WRITE_ACK; w_phase = 1'b0;
                    end
                end
                S_WRITE_ACK: if (w_scl_fall) begin
                    if (!r_phase) begin
                        w_sending = 1'b1; w_phase = 1'b1;
                    end else begin
                        w_sending = 1'b0; w_phase = 1'b0; w_cnt = 3'd0; w_state = S_WRITE;
                    end
                end
                S_READ: if (r_load) begin
`ifdef I2C_TARGET_CLK_STRETCH_EN
                    if (tx_valid_i) begin
                        w_shift = tx_data_i; w_sending = ~tx_data_i[7]; w_load = 1'b0; w_hold = 1'b0;
                    end else begin
                        w_hold = 1'b1;
                    end
`else
                    w_shift = tx_data_i; w_sending = ~tx_data_i[7]; w_load = 1'b0;
`endif
                end else if (w_scl_fall) begin
                    if (r_cnt == 3'd7) begin
                        w_sending = 1'b0; w_cnt = 3'd0; w_phase = 1'b0; w_state = S_READ_ACK;
                    end else begin
                        w_shift   = {r_shift[6:0], 1'b0};
                        w_sending = ~r_shift[6];
                        w_cnt     = r_cnt + 3'd1;
                    end
                end
                S_READ_ACK: if (w_scl_rise) begin
                    if (r_sda_s2) w_state = S_WAIT_STOP;
                    else          w_phase = 1'b1;
                end else if (w_scl_fall && r_phase) begin
                    w_state = S_READ; w_tx_req = 1'b1; w_load = 1'b1; w_phase = 1'b0; w_cnt = 3'd0;
                end
                default: ;
            endcase
        end
    end

    assign sda_o        = 1'b0;
    assign is_sending_o = r_sending;
    assign rx_data_o    = r_rx_data;
    assign rx_valid_o   = r_rx_valid;
    assign tx_req_o     = r_tx_req;
    assign busy_o       = r_busy;
    assign stop_o       = r_stop;
`ifdef I2C_TARGET_CLK_STRETCH_EN
    assign scl_hold_o   = r_hold;
    assign w_unused     = r_shift[7];
`else
    assign scl_hold_o   = 1'b0;
    assign w_unused     = ^{tx_valid_i, r_hold, r_shift[7]};
`endif
endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - directed bench for i2c_target with byte scoreboards and a wired-AND bus model
module tb_i2c_target;
    localparam int Q = 20;
    localparam int H = 6;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_valid_i = 1'b1;
    logic       w_scl, w_sda;
    logic       sda_o, is_sending_o, scl_hold_o, rx_valid_o, tx_req_o, busy_o, stop_o;
    logic [7:0] rx_data_o;

    int errors = 0;
    int checks = 0;
    int n_txreq = 0, n_stop = 0, n_send = 0, n_rxv = 0;
    logic [7:0] rx_q[$];
    logic [7:0] rd_q[$];

    assign w_scl = m_scl & ~scl_hold_o;
    assign w_sda = m_sda & ~is_sending_o;

    i2c_target #(.TARGET_ADDR(7'h3C)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .scl_i(w_scl), .sda_i(w_sda),
        .sda_o(sda_o), .is_sending_o(is_sending_o), .scl_hold_o(scl_hold_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .tx_req_o(tx_req_o),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .busy_o(busy_o), .stop_o(stop_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Event counters and the write-data scoreboard, sampled on the falling edge
    always @(negedge clk_i) begin
        if (tx_req_o) n_txreq++;
        if (stop_o) n_stop++;
        if (is_sending_o) n_send++;
        if (rx_valid_o) begin
            n_rxv++;
            chk("rx_pending", {31'd0, rx_q.size() != 0}, 32'd1);
            if (rx_q.size() != 0) chk("rx_data", {24'd0, rx_data_o}, {24'd0, rx_q.pop_front()});
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic scl_up();
        int k;
        m_scl = 1'b1;
        k = 0;
        while (w_scl !== 1'b1 && k < 5000) begin
            wait_clk(1);
            k++;
        end
        if (w_scl !== 1'b1) chk("scl_stretch_timeout", {31'd0, w_scl}, 32'd1);
    endtask

    task automatic start_c();
        m_sda = 1'b1; wait_clk(Q);
        scl_up(); wait_clk(Q);
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b0; wait_clk(H);
    endtask

    task automatic stop_c();
        m_sda = 1'b0; wait_clk(Q);
        scl_up(); wait_clk(Q);
        m_sda = 1'b1; wait_clk(Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; wait_clk(Q);
        scl_up(); wait_clk(Q);
        m_scl = 1'b0; wait_clk(H);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; wait_clk(Q);
        scl_up(); wait_clk(Q / 2);
        b = w_sda; wait_clk(Q / 2);
        m_scl = 1'b0; wait_clk(H);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    task automatic rd_check(input string tag, input logic [7:0] d);
        chk({tag, "_pending"}, {31'd0, rd_q.size() != 0}, 32'd1);
        if (rd_q.size() != 0) chk(tag, {24'd0, d}, {24'd0, rd_q.pop_front()});
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        logic [7:0] addr_w;
        int         s0, t0, r0, p0;

        // reset state
        wait_clk(3);
        rst_i = 1'b0;
        wait_clk(2);
        chk("rst_sending", {31'd0, is_sending_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_hold", {31'd0, scl_hold_o}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data_o}, 32'd0);
        chk("rst_pulses", {29'd0, rx_valid_o, tx_req_o, stop_o}, 32'd0);
        chk("sda_o_const", {31'd0, sda_o}, 32'd0);

        // write two bytes to our address
        s0 = n_stop; r0 = n_rxv;
        start_c();
        write_byte(8'h78, ack); chk("wr_addr_ack", {31'd0, ack}, 32'd1);
        chk("wr_busy_after_ack", {31'd0, busy_o}, 32'd1);
        rx_q.push_back(8'hA5);
        write_byte(8'hA5, ack); chk("wr_a5_ack", {31'd0, ack}, 32'd1);
        rx_q.push_back(8'h5A);
        write_byte(8'h5A, ack); chk("wr_5a_ack", {31'd0, ack}, 32'd1);
        chk("wr_busy_before_stop", {31'd0, busy_o}, 32'd1);
        stop_c();
        wait_clk(5);
        chk("wr_stop_pulses", s0 + 1, n_stop);
        chk("wr_rx_pulses", r0 + 2, n_rxv);
        chk("wr_busy_after_stop", {31'd0, busy_o}, 32'd0);
        wait_clk(20);

        // wrong address is ignored until STOP
        p0 = n_send; r0 = n_rxv;
        start_c();
        write_byte(8'h7A, ack); chk("mis_addr_nack", {31'd0, ack}, 32'd0);
        write_byte(8'h55, ack); chk("mis_data_nack", {31'd0, ack}, 32'd0);
        chk("mis_busy", {31'd0, busy_o}, 32'd0);
        stop_c();
        wait_clk(5);
        chk("mis_no_drive", n_send, p0);
        chk("mis_no_rx", n_rxv, r0);
        wait_clk(20);

        // read 0xC3 twice, ACK then NACK
        t0 = n_txreq;
        tx_data_i = 8'hC3;
        start_c();
        write_byte(8'h79, ack); chk("rd_addr_ack", {31'd0, ack}, 32'd1);
        rd_q.push_back(8'hC3);
        read_byte(d, 1'b0); rd_check("rd_byte0", d);
        rd_q.push_back(8'hC3);
        read_byte(d, 1'b1); rd_check("rd_byte1", d);
        chk("rd_released", {31'd0, is_sending_o}, 32'd0);
        p0 = n_send;
        write_byte(8'h00, ack);
        chk("rd_wait_stop_ignores", {31'd0, ack}, 32'd0);
        chk("rd_wait_stop_no_drive", n_send, p0);
        chk("rd_txreq_pulses", n_txreq, t0 + 2);
        stop_c();
        wait_clk(20);

        // write then repeated START into a read
        s0 = n_stop;
        start_c();
        write_byte(8'h78, ack); chk("rs_addr_ack", {31'd0, ack}, 32'd1);
        rx_q.push_back(8'h11);
        write_byte(8'h11, ack); chk("rs_11_ack", {31'd0, ack}, 32'd1);
        tx_data_i = 8'h96;
        start_c();
        chk("rs_busy_cleared", {31'd0, busy_o}, 32'd0);
        write_byte(8'h79, ack); chk("rs_rd_addr_ack", {31'd0, ack}, 32'd1);
        rd_q.push_back(8'h96);
        read_byte(d, 1'b1); rd_check("rs_byte", d);
        chk("rs_rx_data", {24'd0, rx_data_o}, 32'h11);
        chk("rs_no_early_stop", n_stop, s0);
        stop_c();
        wait_clk(5);
        chk("rs_final_stop", n_stop, s0 + 1);
        wait_clk(20);

        // reset while the address ACK is driven low
        addr_w = 8'h78;
        start_c();
        for (int i = 7; i >= 0; i--) write_bit(addr_w[i]);
        for (int i = 0; i < 100 && is_sending_o !== 1'b1; i++) wait_clk(1);
        chk("rst_mid_ack_driven", {31'd0, is_sending_o}, 32'd1);
        chk("rst_mid_busy_before", {31'd0, busy_o}, 32'd1);
        rst_i = 1'b1;
        wait_clk(1);
        chk("rst_mid_sending", {31'd0, is_sending_o}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        rst_i = 1'b0;
        m_sda = 1'b1; wait_clk(Q);
        scl_up(); wait_clk(Q);
        start_c();
        write_byte(8'h78, ack); chk("post_rst_addr_ack", {31'd0, ack}, 32'd1);
        rx_q.push_back(8'h3C);
        write_byte(8'h3C, ack); chk("post_rst_data_ack", {31'd0, ack}, 32'd1);
        stop_c();
        wait_clk(20);

`ifdef I2C_TARGET_CLK_STRETCH_EN
        // stretch SCL while the read byte is not yet valid
        tx_valid_i = 1'b0;
        tx_data_i  = 8'h3E;
        start_c();
        write_byte(8'h79, ack); chk("st_addr_ack", {31'd0, ack}, 32'd1);
        rd_q.push_back(8'h3E);
        fork
            read_byte(d, 1'b1);
            begin
                int held;
                for (int i = 0; i < 2000 && scl_hold_o !== 1'b1; i++) wait_clk(1);
                chk("st_hold_seen", {31'd0, scl_hold_o}, 32'd1);
                held = 0;
                for (int i = 0; i < 200; i++) begin
                    wait_clk(1);
                    if (scl_hold_o === 1'b1) held++;
                end
                chk("st_hold_cycles", held, 200);
                tx_valid_i = 1'b1;
                wait_clk(1);
                chk("st_hold_released", {31'd0, scl_hold_o}, 32'd0);
            end
        join
        rd_check("st_byte", d);
        stop_c();
        wait_clk(20);
`endif

        chk("rx_queue_drained", rx_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
